// File: rtl/accum_datapath.sv
// Accumulator-machine execution core: free-running PC, 8-opcode combinational ALU,
// and independently enabled accumulator and carry-flag registers.

module accum_en_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!nReset)
      q <= '0;
    else if (ce)
      q <= d;
  end

endmodule

module accum_datapath #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PC_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [2:0]            alu_code,
  input  logic [DATA_WIDTH-1:0] r_in,
  input  logic                  a_ce,
  input  logic                  cy_ce,
  output logic [PC_WIDTH-1:0]   pc_addr,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic                  cy_out,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  alu_co
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_SBB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_LDR = 3'b111
  } alu_op_e;

  logic [PC_WIDTH-1:0]   pc_q;
  logic [DATA_WIDTH:0]   a_ext;
  logic [DATA_WIDTH:0]   r_ext;
  logic [DATA_WIDTH:0]   ci_ext;
  logic [DATA_WIDTH:0]   alu_res;

  always_ff @(posedge clk) begin
    if (!nReset)
      pc_q <= '0;
    else
      pc_q <= pc_q + 1'b1;
  end

  assign pc_addr = pc_q;

  assign a_ext  = {1'b0, a_out};
  assign r_ext  = {1'b0, r_in};
  assign ci_ext = {{DATA_WIDTH{1'b0}}, cy_out};

  // Subtraction at DATA_WIDTH+1 bits leaves the borrow in the top bit.
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(alu_code))
      OP_ADD:  alu_res = a_ext + r_ext;
      OP_ADC:  alu_res = a_ext + r_ext + ci_ext;
      OP_SUB:  alu_res = a_ext - r_ext;
      OP_SBB:  alu_res = a_ext - r_ext - ci_ext;
      OP_AND:  alu_res = {1'b0, a_out & r_in};
      OP_OR:   alu_res = {1'b0, a_out | r_in};
      OP_XOR:  alu_res = {1'b0, a_out ^ r_in};
      OP_LDR:  alu_res = r_ext;
      default: alu_res = '0;
    endcase
  end

  assign alu_out = alu_res[DATA_WIDTH-1:0];
  assign alu_co  = alu_res[DATA_WIDTH];

  accum_en_reg #(.WIDTH(DATA_WIDTH)) u_acc (
    .clk    (clk),
    .nReset (nReset),
    .ce     (a_ce),
    .d      (alu_out),
    .q      (a_out)
  );

  accum_en_reg #(.WIDTH(1)) u_carry (
    .clk    (clk),
    .nReset (nReset),
    .ce     (cy_ce),
    .d      (alu_co),
    .q      (cy_out)
  );

endmodule

// File: tb/tb_accum_datapath.sv
// Self-checking bench for accum_datapath: directed sequence plus randomized
// stimulus against an arithmetic reference model.

module tb_accum_datapath;

  logic       clk;
  logic       nReset;
  logic [2:0] alu_code;
  logic [7:0] r_in;
  logic       a_ce;
  logic       cy_ce;
  logic [4:0] pc_addr;
  logic [7:0] a_out;
  logic       cy_out;
  logic [7:0] alu_out;
  logic       alu_co;

  int checks   = 0;
  int failures = 0;

  int  m_pc = 0;
  int  m_a  = 0;
  int  m_cy = 0;
  bit  known = 0;

  accum_datapath #(.DATA_WIDTH(8), .PC_WIDTH(5)) dut (
    .clk      (clk),
    .nReset   (nReset),
    .alu_code (alu_code),
    .r_in     (r_in),
    .a_ce     (a_ce),
    .cy_ce    (cy_ce),
    .pc_addr  (pc_addr),
    .a_out    (a_out),
    .cy_out   (cy_out),
    .alu_out  (alu_out),
    .alu_co   (alu_co)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_alu(input int code, input int a, input int r, input int ci,
                                    output int res, output int co);
    int s;
    co = 0;
    case (code)
      0: begin s = a + r;      co = (s > 255) ? 1 : 0; res = s % 256; end
      1: begin s = a + r + ci; co = (s > 255) ? 1 : 0; res = s % 256; end
      2: begin co = (a < r) ? 1 : 0;      res = (a - r + 256) % 256; end
      3: begin co = (a < r + ci) ? 1 : 0; res = (a - r - ci + 512) % 256; end
      4: res = a & r;
      5: res = a | r;
      6: res = a ^ r;
      default: res = r;
    endcase
  endfunction

  // Drives one cycle of inputs, checks the ALU before the edge and state after it.
  task automatic step(input bit rst, input int code, input int r, input bit ace, input bit cyce);
    int o = 0;
    int c = 0;
    nReset   = !rst;
    alu_code = code[2:0];
    r_in     = r[7:0];
    a_ce     = ace;
    cy_ce    = cyce;
    #1;
    if (known) begin
      model_alu(code, m_a, r, m_cy, o, c);
      check("alu_out", alu_out, o);
      check("alu_co", alu_co, c);
    end
    @(posedge clk);
    if (rst) begin
      m_pc = 0; m_a = 0; m_cy = 0; known = 1;
    end else if (known) begin
      m_pc = (m_pc + 1) % 32;
      if (ace)  m_a  = o;
      if (cyce) m_cy = c;
    end
    #1;
    if (known) begin
      check("pc_addr", pc_addr, m_pc);
      check("a_out", a_out, m_a);
      check("cy_out", cy_out, m_cy);
    end
  endtask

  initial begin
    nReset = 0; alu_code = '0; r_in = '0; a_ce = 0; cy_ce = 0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_pc", pc_addr, 0);

    for (int i = 0; i < 34; i++) step(0, 0, $urandom_range(255), 0, 0);
    check("wrap_pc", pc_addr, 2);

    step(0, 7, 'h5A, 1, 0);
    check("ldr_a", a_out, 'h5A);
    check("ldr_cy", cy_out, 0);

    step(0, 7, 'hF0, 1, 0);
    step(0, 0, 'h20, 1, 1);
    check("add_a", a_out, 'h10);
    check("add_cy", cy_out, 1);
    step(0, 1, 'h01, 1, 1);
    check("adc_a", a_out, 'h12);
    check("adc_cy", cy_out, 0);

    step(0, 7, 'h05, 1, 0);
    step(0, 2, 'h07, 1, 1);
    check("sub_a", a_out, 'hFE);
    check("sub_cy", cy_out, 1);
    step(0, 3, 'h00, 1, 1);
    check("sbb_a", a_out, 'hFD);
    check("sbb_cy", cy_out, 0);

    // Set carry while holding A (alu_out differs from a_out).
    step(0, 7, 'h00, 1, 0);
    step(0, 2, 'h01, 0, 1);
    check("hold_a", a_out, 'h00);
    check("hold_cy", cy_out, 1);

    step(0, 7, 'hCC, 1, 0);
    step(0, 4, 'hAA, 1, 0);
    check("and_a", a_out, 'h88);
    step(0, 7, 'hCC, 1, 0);
    step(0, 5, 'hAA, 1, 0);
    check("or_a", a_out, 'hEE);
    step(0, 7, 'hCC, 1, 0);
    step(0, 6, 'hAA, 1, 0);
    check("xor_a", a_out, 'h66);
    check("logic_cy", cy_out, 1);

    step(1, 0, 'hFF, 1, 1);
    check("rstpri_a", a_out, 0);
    check("rstpri_cy", cy_out, 0);
    check("rstpri_pc", pc_addr, 0);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(24) == 0), $urandom_range(7), $urandom_range(255),
           $urandom_range(1), $urandom_range(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_datapath.md
Name: accum_datapath

Overview:
- Minimal accumulator-machine execution core with four parts: a free-running program counter, an 8-bit combinational ALU, an accumulator register and a carry-flag register, each register with its own clock enable.
- An external decoder drives the ALU opcode and the enables, indexed by the program counter.
- An external register file supplies the second operand and receives the accumulator value.

Parameters:
- DATA_WIDTH, 8, width of the ALU operands, ALU result and accumulator.
- PC_WIDTH, 5, width of the program counter (32 instruction addresses).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nReset  input  1  synchronous active-low reset.
- alu_code  input  3  ALU operation select.
- r_in  input  DATA_WIDTH  second ALU operand, from the register file.
- a_ce  input  1  accumulator load enable.
- cy_ce  input  1  carry-flag load enable.
- pc_addr  output  PC_WIDTH  current program-counter value (instruction address).
- a_out  output  DATA_WIDTH  accumulator contents.
- cy_out  output  1  carry-flag contents.
- alu_out  output  DATA_WIDTH  combinational ALU result.
- alu_co  output  1  combinational ALU carry/borrow out.

Behaviour:
- Reset is synchronous: on a rising clk edge with nReset=0, pc_addr, a_out and cy_out all become 0.
- Reset has priority over the enables. Reset asserted mid-operation discards any load in that cycle.
- Program counter:
  - With nReset=1, it increments by 1 on every rising edge.
  - It wraps from 2^PC_WIDTH-1 (31) to 0, with no stall input.
  - First post-reset cycle presents address 0.
- ALU operands: A=a_out, R=r_in, Ci=cy_out. The ALU is purely combinational, so alu_out and alu_co follow any input change with zero latency.
- Arithmetic is computed at DATA_WIDTH+1 bits; alu_co is bit DATA_WIDTH.
- ALU opcodes:
  - 000 ADD: A+R; co = carry out.
  - 001 ADC: A+R+Ci; co = carry out.
  - 010 SUB: A-R; co = 1 when a borrow occurs (A<R).
  - 011 SBB: A-R-Ci; co = 1 when a borrow occurs (A<R+Ci).
  - 100 AND: A&R; co=0.
  - 101 OR: A|R; co=0.
  - 110 XOR: A^R; co=0.
  - 111 LDR (pass R): out=R; co=0.
- Accumulator: on a rising edge with nReset=1 and a_ce=1, a_out <= alu_out. With a_ce=0 it holds.
- Carry flag: on a rising edge with nReset=1 and cy_ce=1, cy_out <= alu_co. With cy_ce=0 it holds.
- a_ce and cy_ce are independent. When both are asserted in the same cycle, both registers sample values computed from the pre-edge A and Ci, so no ordering hazard arises.
- Registers change only on clk edges; there are no latches and no asynchronous paths to state.
- Implementation structure: the accumulator and carry flag are instances of one generic parameterised enabled register (width parameter, CE, synchronous active-low reset), used at widths 8 and 1.

Test Plan:
- Reset, then release with a_ce=cy_ce=0, run 34 cycles -> pc_addr counts 0,1,…,31,0,1; a_out=0 and cy_out=0 throughout.
- LDR: alu_code=111, r_in=0x5A, a_ce=1 for one cycle -> a_out=0x5A next cycle; cy_out unchanged at 0.
- ADD with carry: A=0xF0, alu_code=000, r_in=0x20, a_ce=cy_ce=1 -> a_out=0x10, cy_out=1. Then ADC with r_in=0x01 -> a_out=0x12, cy_out=0.
- SUB with borrow: A=0x05, alu_code=010, r_in=0x07, a_ce=cy_ce=1 -> a_out=0xFE, cy_out=1. Then SBB with r_in=0x00 -> a_out=0xFD, cy_out=0.
- Logic ops with A=0xCC, r_in=0xAA:
  - AND -> 0x88.
  - OR (from A=0xCC) -> 0xEE.
  - XOR (from A=0xCC) -> 0x66.
  - alu_co=0 in every case. With cy_ce=0, a cy_out of 1 is preserved.
- Enable and reset priority:
  - a_ce=0 with alu_out≠a_out -> a_out holds.
  - Assert nReset=0 in the same cycle as a_ce=cy_ce=1 -> a_out=0, cy_out=0, pc_addr=0 after that edge.
